// File: rtl/debounce_bank.sv
// Multi-channel switch conditioner: per-channel two-flop synchroniser, tick-based
// stability window, and registered level / press / release / long-press outputs.
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int STABLE_TICKS = 1024,
    parameter int LONG_TICKS   = 0,
    parameter bit INVERT       = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_long,
    output logic [CHANNELS-1:0] btn_held
);

    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in ^ {CHANNELS{INVERT}};
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;
        logic          long_q;
        logic          held_q;
        logic          accept;

        // Window completes on the tick where s2 has disagreed for STABLE_TICKS ticks.
        assign accept = (s2[i] != level_q) && tick && (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (accept) begin
                    level_q <= s2[i];
                    cnt     <= '0;
                    rise_q  <= s2[i];
                    fall_q  <= ~s2[i];
                end else if (s2[i] == level_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        if (LONG_TICKS > 0) begin : g_long
            localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

            logic [HW-1:0] hcnt;
            logic          level_nxt;

            // Clearing on the next level lets btn_held drop in the btn_fall cycle.
            assign level_nxt = accept ? s2[i] : level_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hcnt   <= '0;
                    long_q <= 1'b0;
                    held_q <= 1'b0;
                end else begin
                    long_q <= 1'b0;
                    if (!level_nxt) begin
                        hcnt   <= '0;
                        held_q <= 1'b0;
                    end else if (level_q && tick && (hcnt < HOLD_MAX)) begin
                        hcnt <= hcnt + 1'b1;
                        if (hcnt == HOLD_LAST) begin
                            long_q <= 1'b1;
                            held_q <= 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_long
            assign long_q = 1'b0;
            assign held_q = 1'b0;
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;
        assign btn_long[i]  = long_q;
        assign btn_held[i]  = held_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: one instance with a 4-tick window and 10-tick long press,
// one inverted instance with a 1-tick window and long-press disabled.
module tb_debounce_bank;

    localparam int RISE = 0;
    localparam int FALL = 1;
    localparam int LONG = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b1;
    logic [3:0] btn_a = 4'hF;
    logic [3:0] btn_b = 4'hF;

    logic [3:0] level_a, rise_a, fall_a, long_a, held_a;
    logic [3:0] level_b, rise_b, fall_b, long_b, held_b;

    debounce_bank #(.CHANNELS(4), .STABLE_TICKS(4), .LONG_TICKS(10), .INVERT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_a),
        .btn_level(level_a), .btn_rise(rise_a), .btn_fall(fall_a),
        .btn_long(long_a), .btn_held(held_a)
    );

    debounce_bank #(.CHANNELS(4), .STABLE_TICKS(1), .LONG_TICKS(0), .INVERT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .btn_in(btn_b),
        .btn_level(level_b), .btn_rise(rise_b), .btn_fall(fall_b),
        .btn_long(long_b), .btn_held(held_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int at;
        int dut;
        int kind;
        int ch;
    } exp_t;

    typedef struct {
        logic [3:0] in;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[14];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;
    bit   sb_en  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_pulse(input int dut, input int kind, input logic [3:0] chans, input int at);
        for (int c = 0; c < 4; c++) begin
            if (chans[c]) sb_q.push_back('{at: at, dut: dut, kind: kind, ch: c});
        end
    endtask

    function automatic logic [3:0] observed(input int d, input int k);
        if (d == 0) return (k == RISE) ? rise_a : (k == FALL) ? fall_a : long_a;
        return (k == RISE) ? rise_b : (k == FALL) ? fall_b : long_b;
    endfunction

    // Every pulse seen or due this cycle is compared, so stray pulses fail too.
    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] e;
                logic [3:0] o;
                e = 4'h0;
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].at == cyc && sb_q[i].dut == d && sb_q[i].kind == k) begin
                        e[sb_q[i].ch] = 1'b1;
                        sb_q.delete(i);
                    end
                end
                o = observed(d, k);
                if (e != 4'h0 || o != 4'h0)
                    check($sformatf("pulse dut%0d %s @%0d", d,
                          (k == RISE) ? "rise" : (k == FALL) ? "fall" : "long", cyc), 32'(o), 32'(e));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sb_en) monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base;

        tbl = '{
            '{4'h1, 4'h0, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0, 4'h0},
            '{4'h1, 4'h0, 4'h0, 4'h0}, '{4'h1, 4'h0, 4'h0, 4'h0},
            '{4'h1, 4'h0, 4'h0, 4'h0}, '{4'h1, 4'h1, 4'h1, 4'h0},
            '{4'h1, 4'h1, 4'h0, 4'h0}, '{4'h0, 4'h1, 4'h0, 4'h0},
            '{4'h0, 4'h1, 4'h0, 4'h0}, '{4'h0, 4'h1, 4'h0, 4'h0},
            '{4'h0, 4'h1, 4'h0, 4'h0}, '{4'h0, 4'h1, 4'h0, 4'h0},
            '{4'h0, 4'h0, 4'h0, 4'h1}, '{4'h0, 4'h0, 4'h0, 4'h0}
        };

        // Reset with all inputs asserted, then release and debounce every channel.
        run(3);
        check("reset_hold_a", 32'({level_a, rise_a, fall_a, long_a, held_a}), 32'h0);
        check("reset_hold_b", 32'({level_b, rise_b, fall_b, long_b, held_b}), 32'h0);
        reset = 1'b1;
        #0;
        check("release_a", 32'({level_a, rise_a, fall_a, long_a, held_a}), 32'h0);
        check("release_b", 32'({level_b, rise_b, fall_b, long_b, held_b}), 32'h0);
        expect_pulse(0, RISE, 4'hF, cyc + 6);
        expect_pulse(0, LONG, 4'hF, cyc + 16);
        run(20);
        check("level_after_reset", 32'(level_a), 32'hF);
        check("held_after_reset", 32'(held_a), 32'hF);
        btn_a = 4'h0;
        expect_pulse(0, FALL, 4'hF, cyc + 6);
        run(5);
        check("held_before_fall", 32'(held_a), 32'hF);
        run(1);
        check("held_at_fall", 32'(held_a), 32'h0);
        check("level_at_fall", 32'(level_a), 32'h0);
        run(4);

        // Clean press and release on ch0, every output compared each cycle.
        sb_en = 1'b0;
        for (int r = 0; r < 14; r++) begin
            btn_a = tbl[r].in;
            step();
            check($sformatf("table row %0d", r),
                  32'({level_a, rise_a, fall_a, long_a, held_a}),
                  32'({tbl[r].lvl, tbl[r].rise, tbl[r].fall, 8'h00}));
        end
        sb_en = 1'b1;

        // Bounce on ch1: 2-clock pulses never fill the window.
        for (int t = 0; t < 10; t++) begin
            btn_a[1] = (t % 2 == 0);
            run(2);
        end
        btn_a[1] = 1'b1;
        expect_pulse(0, RISE, 4'h2, cyc + 6);
        expect_pulse(0, LONG, 4'h2, cyc + 16);
        run(5);
        check("bounce_not_yet", 32'(level_a[1]), 32'h0);
        run(1);
        check("bounce_settled", 32'(level_a[1]), 32'h1);
        run(12);
        btn_a[1] = 1'b0;
        expect_pulse(0, FALL, 4'h2, cyc + 6);
        run(8);

        // Long press on ch2 held well past the long threshold.
        btn_a[2] = 1'b1;
        expect_pulse(0, RISE, 4'h4, cyc + 6);
        expect_pulse(0, LONG, 4'h4, cyc + 16);
        run(15);
        check("held_before_long", 32'(held_a[2]), 32'h0);
        run(1);
        check("held_at_long", 32'(held_a[2]), 32'h1);
        run(40);
        btn_a[2] = 1'b0;
        expect_pulse(0, FALL, 4'h4, cyc + 6);
        run(5);
        check("held_until_fall", 32'(held_a[2]), 32'h1);
        run(1);
        check("held_drop_at_fall", 32'(held_a[2]), 32'h0);
        run(3);

        // Prescale: tick on every third clock; ch3 accepted on the 4th tick edge.
        base = cyc;
        expect_pulse(0, RISE, 4'h8, base + 1 + 11);
        expect_pulse(0, LONG, 4'h8, base + 1 + 41);
        for (int i = 0; i < 44; i++) begin
            tick = (i % 3 == 2);
            if (i == 0) btn_a[3] = 1'b1;
            step();
        end
        check("held_sparse_tick", 32'(held_a[3]), 32'h1);

        // One-clock glitch on ch0 after two ticks restarts its window.
        base = cyc;
        expect_pulse(0, RISE, 4'h1, base + 1 + 20);
        expect_pulse(0, LONG, 4'h1, base + 1 + 50);
        for (int i = 0; i < 53; i++) begin
            tick = (i % 3 == 2);
            btn_a[0] = (i != 6);
            step();
        end
        tick  = 1'b1;
        btn_a = 4'h0;
        expect_pulse(0, FALL, 4'h9, cyc + 6);
        run(6);
        check("held_after_dual_fall", 32'(held_a), 32'h0);
        run(2);

        // Inverted instance: all channels pulled low together, 1-tick window.
        btn_b = 4'h0;
        expect_pulse(1, RISE, 4'hF, cyc + 3);
        run(3);
        check("inv_level", 32'(level_b), 32'hF);
        run(10);
        check("inv_held_disabled", 32'(held_b), 32'h0);
        btn_b = 4'hF;
        expect_pulse(1, FALL, 4'hF, cyc + 3);
        run(5);

        // Asynchronous reset while ch2/ch3 are pressed and ch0 is mid-window.
        btn_a = 4'hC;
        expect_pulse(0, RISE, 4'hC, cyc + 6);
        expect_pulse(0, LONG, 4'hC, cyc + 16);
        run(20);
        check("pre_reset_level", 32'(level_a), 32'hC);
        btn_a[0] = 1'b1;
        run(4);
        reset = 1'b0;
        #1;
        check("reset_mid_window", 32'({level_a, rise_a, fall_a, long_a, held_a}), 32'h0);
        btn_a = 4'h0;
        run(3);
        reset = 1'b1;
        run(10);
        check("post_reset_quiet", 32'({level_a, held_a}), 32'h0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
